// File: rtl/amp_i2c_arbiter_if.sv
// Command/completion bus between the arbiter and the amp I2C byte
// write engine. master = arbiter side, slave = engine side.
interface amp_i2c_arbiter_if;
  logic       m_valid;
  logic       m_ready;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic       m_done;
  logic       m_nack;

  modport master (
    output m_valid, m_addr, m_data,
    input  m_ready, m_done, m_nack
  );

  modport slave (
    input  m_valid, m_addr, m_data,
    output m_ready, m_done, m_nack
  );
endinterface

// File: rtl/amp_i2c_arbiter.sv
// Round-robin arbiter sharing one amp I2C write engine between two ports.
// It caches the amp register page, inserts page-select writes on a page
// change and retries NACKed writes up to MAX_RETRY times.
// Ports: clk_in, reset (sync, active high);
//   a_*/b_* requester ports (req/page/addr/data in, ack/err out);
//   m (amp_i2c_arbiter_if.master) engine command/done bus;
//   busy, cur_page, page_vld status.
// Optional: define AMP_ARB_TIMEOUT_EN to abort engine waits after TIMEOUT.
module amp_i2c_arbiter #(
  parameter logic [6:0] PAGE_REG  = 7'h7F,
  parameter int         MAX_RETRY = 2,
  parameter int         TIMEOUT   = 1023
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       a_req,
  input  logic [5:0] a_page,
  input  logic [6:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ack,
  output logic       a_err,
  input  logic       b_req,
  input  logic [5:0] b_page,
  input  logic [6:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ack,
  output logic       b_err,
  amp_i2c_arbiter_if.master m,
  output logic       busy,
  output logic [5:0] cur_page,
  output logic       page_vld
);

  if (MAX_RETRY < 0 || MAX_RETRY > 7 || TIMEOUT < 1)
  begin : g_bad_cfg
    $error("amp_i2c_arbiter: bad parameters");
  end

  typedef enum logic [2:0] {
    IDLE, GRANT, PG_ISSUE, PG_WAIT,
    WR_ISSUE, WR_WAIT, RESP
  } state_t;

  localparam logic [2:0] RMAX = 3'(MAX_RETRY);

  state_t     state, state_n;
  logic       gnt, gnt_n;
  logic       last_b, last_b_n;
  logic [5:0] r_page, page_n;
  logic [6:0] r_addr, addr_n;
  logic [7:0] r_data, data_n;
  logic [2:0] retry, retry_n;
  logic       err, err_n;
  logic [5:0] cpage_n;
  logic       pvld_n;
  logic [6:0] maddr_q, maddr_n;
  logic [7:0] mdata_q, mdata_n;

`ifdef AMP_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo;
  logic          tmo_run;
  logic          tmo_evt;
  logic          tmo_hit;

  assign tmo_run = (state == PG_ISSUE) || (state == PG_WAIT) ||
                   (state == WR_ISSUE) || (state == WR_WAIT);
  // Issue states wait for acceptance, wait states for completion.
  assign tmo_evt = (state == PG_ISSUE || state == WR_ISSUE) ?
                   m.m_ready : m.m_done;
  assign tmo_hit = tmo_run && !tmo_evt && (tmo == TMO_LAST);

  // Restarts from zero on every state entry, including retries.
  always_ff @(posedge clk_in) begin
    if (reset || state_n != state || !tmo_run) tmo <= '0;
    else tmo <= tmo + TW'(1);
  end
`endif

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    last_b_n = last_b;
    page_n   = r_page;
    addr_n   = r_addr;
    data_n   = r_data;
    retry_n  = retry;
    err_n    = err;
    cpage_n  = cur_page;
    pvld_n   = page_vld;
    maddr_n  = maddr_q;
    mdata_n  = mdata_q;
    unique case (state)
      IDLE: begin
        if (a_req || b_req) begin
          // B wins alone, or on a tie when A was served last.
          gnt_n    = b_req && (!a_req || !last_b);
          last_b_n = gnt_n;
          page_n   = gnt_n ? b_page : a_page;
          addr_n   = gnt_n ? b_addr : a_addr;
          data_n   = gnt_n ? b_data : a_data;
          state_n  = GRANT;
        end
      end
      GRANT: begin
        retry_n = '0;
        err_n   = 1'b0;
        if (page_vld && cur_page == r_page) begin
          maddr_n = r_addr;
          mdata_n = r_data;
          state_n = WR_ISSUE;
        end else begin
          maddr_n = PAGE_REG;
          mdata_n = {2'b00, r_page};
          state_n = PG_ISSUE;
        end
      end
      PG_ISSUE: if (m.m_ready) state_n = PG_WAIT;
      PG_WAIT: begin
        if (m.m_done) begin
          if (!m.m_nack) begin
            cpage_n = r_page;
            pvld_n  = 1'b1;
            retry_n = '0;
            maddr_n = r_addr;
            mdata_n = r_data;
            state_n = WR_ISSUE;
          end else begin
            pvld_n = 1'b0;
            if (retry < RMAX) begin
              retry_n = retry + 3'd1;
              state_n = PG_ISSUE;
            end else begin
              err_n   = 1'b1;
              state_n = RESP;
            end
          end
        end
      end
      WR_ISSUE: if (m.m_ready) state_n = WR_WAIT;
      WR_WAIT: begin
        if (m.m_done) begin
          if (!m.m_nack) begin
            err_n   = 1'b0;
            state_n = RESP;
          end else if (retry < RMAX) begin
            retry_n = retry + 3'd1;
            state_n = WR_ISSUE;
          end else begin
            err_n   = 1'b1;
            state_n = RESP;
          end
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef AMP_ARB_TIMEOUT_EN
    if (tmo_hit) begin
      err_n   = 1'b1;
      pvld_n  = 1'b0;
      state_n = RESP;
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_b   <= 1'b1;
      r_page   <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      retry    <= '0;
      err      <= 1'b0;
      cur_page <= '0;
      page_vld <= 1'b0;
      maddr_q  <= '0;
      mdata_q  <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      last_b   <= last_b_n;
      r_page   <= page_n;
      r_addr   <= addr_n;
      r_data   <= data_n;
      retry    <= retry_n;
      err      <= err_n;
      cur_page <= cpage_n;
      page_vld <= pvld_n;
      maddr_q  <= maddr_n;
      mdata_q  <= mdata_n;
    end
  end

  assign m.m_valid = (state == PG_ISSUE) || (state == WR_ISSUE);
  assign m.m_addr  = maddr_q;
  assign m.m_data  = mdata_q;

  assign a_ack = (state == RESP) && !gnt;
  assign b_ack = (state == RESP) && gnt;
  assign a_err = a_ack && err;
  assign b_err = b_ack && err;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_amp_i2c_arbiter.sv
// Self-checking bench for amp_i2c_arbiter: engine model plus
// scoreboards of expected engine commands and requester acks.
module tb_amp_i2c_arbiter;
  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [5:0] a_page = '0, b_page = '0;
  logic [6:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ack, a_err, b_ack, b_err;
  logic       busy, page_vld;
  logic [5:0] cur_page;

  amp_i2c_arbiter_if bus();

  amp_i2c_arbiter #(.TIMEOUT(20)) dut (
    .clk_in(clk_in), .reset(reset),
    .a_req(a_req), .a_page(a_page), .a_addr(a_addr),
    .a_data(a_data), .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_page(b_page), .b_addr(b_addr),
    .b_data(b_data), .b_ack(b_ack), .b_err(b_err),
    .m(bus.master),
    .busy(busy), .cur_page(cur_page), .page_vld(page_vld)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;

  logic [14:0] exp_cmd[$];
  logic [1:0]  exp_ack[$];
  bit          nack_q[$];
  bit          ready_en = 1'b1;

  // Engine model: accepts one command, completes it two cycles later.
  initial begin
    logic [14:0] got, exp;
    bus.m_ready = 1'b0;
    bus.m_done  = 1'b0;
    bus.m_nack  = 1'b0;
    forever begin
      @(negedge clk_in);
      if (bus.m_valid === 1'b1 && ready_en && !reset) begin
        got = {bus.m_addr, bus.m_data};
        n_chk++;
        if (exp_cmd.size() == 0) begin
          n_fail++;
          $display("FAIL cmd: got %h, required none", got);
        end else begin
          exp = exp_cmd.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL cmd: got %h, required %h", got, exp);
          end
        end
        bus.m_ready = 1'b1;
        @(negedge clk_in);
        bus.m_ready = 1'b0;
        repeat (2) @(negedge clk_in);
        bus.m_nack = (nack_q.size() != 0) ? nack_q.pop_front() : 1'b0;
        bus.m_done = 1'b1;
        @(negedge clk_in);
        bus.m_done = 1'b0;
        bus.m_nack = 1'b0;
      end
    end
  end

  // Ack monitor: {port(1=B), err} against the scoreboard.
  always @(negedge clk_in) begin
    logic [1:0] got, exp;
    if (a_ack === 1'b1 || b_ack === 1'b1) begin
      n_chk++;
      got = {b_ack, b_ack ? b_err : a_err};
      if (a_ack && b_ack) begin
        n_fail++;
        $display("FAIL ack: both ports acked");
      end else if (exp_ack.size() == 0) begin
        n_fail++;
        $display("FAIL ack: got %b, required none", got);
      end else begin
        exp = exp_ack.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL ack: got %b, required %b", got, exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input bit port, input logic [5:0] pg,
                        input logic [6:0] ad, input logic [7:0] dt);
    int n = 0;
    if (port) begin
      b_page = pg; b_addr = ad; b_data = dt; b_req = 1'b1;
    end else begin
      a_page = pg; a_addr = ad; a_data = dt; a_req = 1'b1;
    end
    do begin
      @(negedge clk_in);
      n++;
    end while (!(port ? b_ack : a_ack) && n < 500);
    if (port) b_req = 1'b0;
    else a_req = 1'b0;
    if ((port ? b_ack : a_ack) !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_wait: port %0d got no ack, required ack", port);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    n_chk++;
    if ({a_ack, a_err, b_ack, b_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_ack: got %b, required 0000",
               {a_ack, a_err, b_ack, b_err});
    end
    n_chk++;
    if ({bus.m_valid, bus.m_addr, bus.m_data} !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_m: got %h, required 0000",
               {bus.m_valid, bus.m_addr, bus.m_data});
    end
    n_chk++;
    if ({busy, page_vld, cur_page} !== 8'h0) begin
      n_fail++;
      $display("FAIL rst_stat: got %h, required 00",
               {busy, page_vld, cur_page});
    end
    reset = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_basic();
    exp_cmd.push_back({7'h7F, 8'h01});
    exp_cmd.push_back({7'h40, 8'h18});
    exp_ack.push_back(2'b00);
    do_req(1'b0, 6'd1, 7'h40, 8'h18);
    n_chk++;
    if ({page_vld, cur_page} !== {1'b1, 6'd1}) begin
      n_fail++;
      $display("FAIL basic_page: got %b/%0d, required 1/1",
               page_vld, cur_page);
    end
    @(negedge clk_in);
  endtask

  // Cached page: command appears in the third cycle counting
  // the IDLE cycle that samples the request.
  task automatic test_repeat();
    exp_cmd.push_back({7'h35, 8'h08});
    exp_ack.push_back(2'b00);
    a_page = 6'd1; a_addr = 7'h35; a_data = 8'h08; a_req = 1'b1;
    @(negedge clk_in);
    n_chk++;
    if (bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_early: m_valid %b, required 0", bus.m_valid);
    end
    @(negedge clk_in);
    n_chk++;
    if (bus.m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lat: m_valid %b, required 1", bus.m_valid);
    end
    do_req(1'b0, 6'd1, 7'h35, 8'h08);
    @(negedge clk_in);
  endtask

  task automatic test_tie();
    do_reset();
    // Tie after reset: A first, then B.
    exp_cmd.push_back({7'h7F, 8'h01});
    exp_cmd.push_back({7'h20, 8'h11});
    exp_cmd.push_back({7'h21, 8'h22});
    exp_ack.push_back(2'b00);
    exp_ack.push_back(2'b10);
    fork
      do_req(1'b0, 6'd1, 7'h20, 8'h11);
      do_req(1'b1, 6'd1, 7'h21, 8'h22);
    join
    @(negedge clk_in);
    // B served last: tie goes to A.
    exp_cmd.push_back({7'h22, 8'h33});
    exp_cmd.push_back({7'h23, 8'h44});
    exp_ack.push_back(2'b00);
    exp_ack.push_back(2'b10);
    fork
      do_req(1'b0, 6'd1, 7'h22, 8'h33);
      do_req(1'b1, 6'd1, 7'h23, 8'h44);
    join
    @(negedge clk_in);
    // A alone, then a tie goes to B.
    exp_cmd.push_back({7'h24, 8'h55});
    exp_ack.push_back(2'b00);
    do_req(1'b0, 6'd1, 7'h24, 8'h55);
    @(negedge clk_in);
    exp_cmd.push_back({7'h25, 8'h66});
    exp_cmd.push_back({7'h26, 8'h77});
    exp_ack.push_back(2'b10);
    exp_ack.push_back(2'b00);
    fork
      do_req(1'b0, 6'd1, 7'h26, 8'h77);
      do_req(1'b1, 6'd1, 7'h25, 8'h66);
    join
    @(negedge clk_in);
  endtask

  task automatic test_page_retry();
    nack_q.push_back(1'b1);
    nack_q.push_back(1'b1);
    repeat (3) exp_cmd.push_back({7'h7F, 8'h02});
    exp_cmd.push_back({7'h10, 8'h5A});
    exp_ack.push_back(2'b10);
    do_req(1'b1, 6'd2, 7'h10, 8'h5A);
    n_chk++;
    if ({page_vld, cur_page} !== {1'b1, 6'd2}) begin
      n_fail++;
      $display("FAIL pg_retry: got %b/%0d, required 1/2",
               page_vld, cur_page);
    end
    @(negedge clk_in);
  endtask

  task automatic test_data_nack();
    repeat (3) nack_q.push_back(1'b1);
    repeat (3) exp_cmd.push_back({7'h11, 8'hA5});
    exp_ack.push_back(2'b01);
    do_req(1'b0, 6'd2, 7'h11, 8'hA5);
    n_chk++;
    if ({page_vld, cur_page} !== {1'b1, 6'd2}) begin
      n_fail++;
      $display("FAIL wr_nack_page: got %b/%0d, required 1/2",
               page_vld, cur_page);
    end
    n_chk++;
    if (nack_q.size() != 0) begin
      n_fail++;
      $display("FAIL wr_nack_cnt: %0d nacks unused, required 0",
               nack_q.size());
    end
    @(negedge clk_in);
  endtask

  task automatic test_reset_midop();
    int n = 0;
    exp_cmd.push_back({7'h12, 8'h3C});
    b_page = 6'd2; b_addr = 7'h12; b_data = 8'h3C; b_req = 1'b1;
    while (bus.m_valid !== 1'b1 && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    while (bus.m_valid === 1'b1 && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    n_chk++;
    if (n >= 50 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_wait: busy %b after %0d cycles, required 1",
               busy, n);
    end
    reset = 1'b1;
    b_req = 1'b0;
    @(negedge clk_in);
    n_chk++;
    if ({bus.m_valid, busy, page_vld} !== 3'b000) begin
      n_fail++;
      $display("FAIL midop_rst: got %b, required 000",
               {bus.m_valid, busy, page_vld});
    end
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

`ifdef AMP_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int hi = 0;
    int n  = 0;
    exp_cmd.push_back({7'h7F, 8'h03});
    exp_cmd.push_back({7'h13, 8'h01});
    exp_ack.push_back(2'b00);
    do_req(1'b0, 6'd3, 7'h13, 8'h01);
    @(negedge clk_in);
    ready_en = 1'b0;
    exp_ack.push_back(2'b01);
    a_page = 6'd3; a_addr = 7'h14; a_data = 8'h02; a_req = 1'b1;
    do begin
      @(negedge clk_in);
      n++;
      if (bus.m_valid === 1'b1) hi++;
    end while (a_ack !== 1'b1 && n < 200);
    a_req = 1'b0;
    n_chk++;
    if (hi != 20) begin
      n_fail++;
      $display("FAIL tmo_len: m_valid %0d cycles, required 20", hi);
    end
    n_chk++;
    if (page_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_page: page_vld %b, required 0", page_vld);
    end
    ready_en = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_tie();
    test_page_retry();
    test_data_nack();
    test_reset_midop();
`ifdef AMP_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (4) @(negedge clk_in);
    n_chk++;
    if (exp_cmd.size() != 0 || exp_ack.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d cmds %0d acks left, required 0 0",
               exp_cmd.size(), exp_ack.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
